// File: rtl/stack_pkg.sv
// Shared definitions for the LIFO stack: request decode enum, reset values
// and the width helper used to size pointers and counters.
package stack_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_SWAP = 2'b11
  } stack_op_e;

  localparam logic RST_PULSE = 1'b0;
  localparam logic RST_FLAG  = 1'b0;

  // Smallest r with 2**r >= value; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/stack_ram.sv
// DEPTH x WIDTH storage with synchronous write and registered read.
// A read and write to the same address on one edge returns the old word.
module stack_ram
  import stack_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register holds between reads so the popped word stays visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/lifo_stack_ctrl.sv
// Parametrised LIFO stack: occupancy pointer, status decode, sticky error
// flags and single-cycle push/pop/dout_valid pulses around a stack_ram.
module lifo_stack_ctrl
  import stack_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int AW    = clog2(DEPTH),
  localparam int CW    = clog2(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             push_req,
  input  logic             pop_req,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_err,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [AW-1:0]    addr,
  output logic             push,
  output logic             pop,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             O,
  output logic             U
);

  stack_op_e        op_p0;
  logic [AW-1:0]    push_addr_p0;
  logic [AW-1:0]    top_addr_p0;
  logic [CW-1:0]    count_nxt_p0;
  logic [AW-1:0]    addr_nxt_p0;
  logic             push_nxt_p0;
  logic             pop_nxt_p0;
  logic             wr_en_p0;
  logic             rd_en_p0;
  logic [AW-1:0]    wr_addr_p0;
  logic [AW-1:0]    rd_addr_p0;
  logic             ovf_p0;
  logic             unf_p0;

  // Status decodes only from the count register, never from requests.
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  assign op_p0        = stack_op_e'({push_req, pop_req});
  assign push_addr_p0 = AW'(count);
  assign top_addr_p0  = AW'(count - CW'(1));

  // Stage p0: request decode and next-state computation
  always_comb begin
    count_nxt_p0 = count;
    addr_nxt_p0  = addr;
    push_nxt_p0  = 1'b0;
    pop_nxt_p0   = 1'b0;
    wr_en_p0     = 1'b0;
    rd_en_p0     = 1'b0;
    wr_addr_p0   = push_addr_p0;
    rd_addr_p0   = top_addr_p0;
    ovf_p0       = 1'b0;
    unf_p0       = 1'b0;
    unique case (op_p0)
      OP_IDLE: ;
      OP_PUSH: begin
        if (!full) begin
          wr_en_p0     = 1'b1;
          addr_nxt_p0  = push_addr_p0;
          count_nxt_p0 = count + CW'(1);
          push_nxt_p0  = 1'b1;
        end else begin
          ovf_p0 = 1'b1;
        end
      end
      OP_POP: begin
        if (!empty) begin
          rd_en_p0     = 1'b1;
          addr_nxt_p0  = top_addr_p0;
          count_nxt_p0 = count - CW'(1);
          pop_nxt_p0   = 1'b1;
        end else begin
          unf_p0 = 1'b1;
        end
      end
      OP_SWAP: begin
        // Replace-top relies on the RAM returning the old word on a
        // same-address read/write; on an empty stack it degrades to a push.
        if (!empty) begin
          rd_en_p0    = 1'b1;
          wr_en_p0    = 1'b1;
          wr_addr_p0  = top_addr_p0;
          addr_nxt_p0 = top_addr_p0;
          push_nxt_p0 = 1'b1;
          pop_nxt_p0  = 1'b1;
        end else begin
          wr_en_p0     = 1'b1;
          addr_nxt_p0  = push_addr_p0;
          count_nxt_p0 = count + CW'(1);
          push_nxt_p0  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Stage p1: registered state, pulses and sticky flags
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count      <= '0;
      addr       <= '0;
      push       <= RST_PULSE;
      pop        <= RST_PULSE;
      dout_valid <= RST_PULSE;
      O          <= RST_FLAG;
      U          <= RST_FLAG;
    end else begin
      count      <= count_nxt_p0;
      addr       <= addr_nxt_p0;
      push       <= push_nxt_p0;
      pop        <= pop_nxt_p0;
      dout_valid <= pop_nxt_p0;
      O          <= ovf_p0 | (O & ~clr_err);
      U          <= unf_p0 | (U & ~clr_err);
    end
  end

  // A reset edge must not disturb storage even if a request is present.
  stack_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk     (Clk),
    .rst     (Reset),
    .wr_en   (wr_en_p0 & ~Reset),
    .wr_addr (wr_addr_p0),
    .wr_data (din),
    .rd_en   (rd_en_p0 & ~Reset),
    .rd_addr (rd_addr_p0),
    .rd_data (dout)
  );

endmodule
